rpn_calc_core: RTL and testbench
================================

// Module: rpn_calc_core
// PURPOSE
//  Parametrised successor of the 16-bit lab calculator FSM: debounced Enter/Undo buttons step
//  through operand A -> operand B -> opcode -> result, with a C_WIDTH-bit ALU and NZCV flags.
//  Sits between the board switches/buttons and the 7-segment driver.
//  Serves as both synthesisable RTL and the bench reference model for later calculator labs.
// PARAMETERS
//  C_WIDTH            16  operand/result width in bits (>=4)
//  C_DEBOUNCER_DELAY  10  consecutive stable cycles before a button level is accepted (>=2)
//  C_BUTTON_EDGE      0   0: act on accepted press (0->1); 1: act on accepted release (1->0)
// PORTS
//  clk      in   1        system clock, rising edge
//  rst_n    in   1        asynchronous active-low reset
//  enter    in   1        raw Enter button, asynchronous to clk, bouncy
//  undo     in   1        raw Undo button, asynchronous to clk, bouncy
//  value    in   C_WIDTH  switch value: operand in S_A/S_B; opcode = value[2:0] in S_OP
//  display  out  C_WIDTH  number for the 7-seg driver
//  flags    out  4        {N,Z,C,V} of last result
//  state    out  2        0 S_A, 1 S_B, 2 S_OP, 3 S_RES
// BEHAVIOUR
//  Reset (any time, incl. mid-debounce): state=S_A; A=B=result=0; op=0; display=0; flags=0;
//   debouncer counters and accepted levels = 0.
//  Inputs: 2-flop synchroniser per button.
//  Debounce: counter resets on every change of the synchronised level; when the new level has
//   been stable C_DEBOUNCER_DELAY cycles it is accepted.
//   Accepting the selected edge yields a 1-cycle pulse (enter_p/undo_p).
//  FSM acts in the cycle after the pulse; state/display/flags update at that clock edge.
//  undo_p and enter_p in the same cycle: undo wins, enter discarded.
//  enter_p: S_A: A<=value, ->S_B
//           S_B: B<=value, ->S_OP
//           S_OP: op<=value[2:0], result/flags registered, ->S_RES
//           S_RES: ->S_A, or chain (see CONFIGURATION)
//  undo_p: S_B->S_A; S_OP->S_B; S_RES->S_OP with flags<=0; S_A: no effect.
//   Registers A/B/op are overwritten only on the next enter.
//  display: registered each cycle: value in S_A/S_B; {0..,value[2:0]} in S_OP; result in S_RES.
//  ALU, unsigned width C_WIDTH, result truncated to C_WIDTH:
//   0 ADD: C=carry out, V=signed overflow
//   1 SUB A-B: C=borrow (A<B unsigned), V=signed overflow
//   2 AND; 3 OR; 4 XOR: C=V=0
//   5 SHL, 6 SHR (logical) by B[$clog2(C_WIDTH)-1:0]: C=V=0
//   7 PASS B: C=V=0
//   N=result[C_WIDTH-1]; Z=(result==0).
//  flags hold their value until the next S_OP->S_RES, undo from S_RES, or reset.
//  Bounce shorter than C_DEBOUNCER_DELAY never produces a pulse.
//  A held button produces exactly one pulse.
// CONFIGURATION
//  RPN_CHAIN_EN defined:
//   enter_p in S_RES does A<=result, ->S_B (result chaining); display shows value from next cycle.
//   undo_p in S_B after a chain returns to S_RES, restores the last result and flags
//   (one-level history register).
//  RPN_CHAIN_EN undefined:
//   enter_p in S_RES -> S_A, A unchanged; undo_p in S_B always -> S_A; no history register.
// TESTING (C_WIDTH=16, C_DEBOUNCER_DELAY=10, C_BUTTON_EDGE=0 unless stated)
//  1. Enter 0x7FFF, 0x0001, op 0 -> display 0x8000, flags N=1 Z=0 C=0 V=1, state 3.
//  2. Enter 0x0003, 0x0005, op 1 -> display 0xFFFE, flags {1,0,1,0}; then undo -> state 2, flags 0.
//  3. Enter toggling every 3 cycles for 40 cycles, then released -> no state change.
//     Enter held 200 cycles -> exactly one advance.
//  4. Enter and undo accepted same cycle in S_OP -> state 1 (undo wins).
//  5. rst_n low mid-debounce in S_OP -> state 0, display 0, flags 0; first press after release
//     needs full delay.
//  6. RPN_CHAIN_EN: 0x0002+0x0003 =5, enter, B=0x0004, op 0 -> 0x0009.
//     Undo from S_B after chain -> state 3, display 0x0005.
//     C_BUTTON_EDGE=1: action only after release is accepted.

Source files
------------

// File: rtl/rpn_calc_core.sv
// Four-step RPN calculator core: debounced Enter/Undo walk A -> B -> opcode -> result with NZCV flags.
// Optional RPN_CHAIN_EN: result chaining into A with a one-level undo history.
module rpn_calc_core #(
   parameter int unsigned C_WIDTH           = 16,
   parameter int unsigned C_DEBOUNCER_DELAY = 10,
   parameter bit          C_BUTTON_EDGE     = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enter,
   input  logic               undo,
   input  logic [C_WIDTH-1:0] value,
   output logic [C_WIDTH-1:0] display,
   output logic [3:0]         flags,
   output logic [1:0]         state
);

   localparam int unsigned CNT_W = $clog2(C_DEBOUNCER_DELAY);
   localparam int unsigned SH_W  = $clog2(C_WIDTH);
   localparam int unsigned MSB   = C_WIDTH - 1;
   localparam int unsigned NBTN  = 2;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;

   typedef enum logic [1:0] {
      S_A   = 2'd0,
      S_B   = 2'd1,
      S_OP  = 2'd2,
      S_RES = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------------
   // Button conditioning: bit 0 = enter, bit 1 = undo
   logic [NBTN-1:0]  btn_raw;
   logic [NBTN-1:0]  sync1_q, sync2_q, sync_d_q, level_q, pulse_q;
   logic [CNT_W-1:0] cnt_q [NBTN];
   logic             enter_p, undo_p;

   assign btn_raw = {undo, enter};
   assign enter_p = pulse_q[0];
   assign undo_p  = pulse_q[1];

   // Counter restarts on any synchronised change; the level is accepted after DELAY stable cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         sync_d_q <= '0;
         level_q  <= '0;
         pulse_q  <= '0;
         for (int i = 0; i < int'(NBTN); i++) cnt_q[i] <= '0;
      end else begin
         sync1_q  <= btn_raw;
         sync2_q  <= sync1_q;
         sync_d_q <= sync2_q;
         pulse_q  <= '0;
         for (int i = 0; i < int'(NBTN); i++) begin
            if ((sync2_q[i] != sync_d_q[i]) || (sync2_q[i] == level_q[i])) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_W'(C_DEBOUNCER_DELAY - 2)) begin
               cnt_q[i]   <= '0;
               level_q[i] <= sync2_q[i];
               pulse_q[i] <= (sync2_q[i] == ~C_BUTTON_EDGE);
            end else begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------------
   // ALU: returns {N,Z,C,V, result}
   function automatic logic [C_WIDTH+3:0] alu_eval(input logic [C_WIDTH-1:0] a,
                                                   input logic [C_WIDTH-1:0] b,
                                                   input logic [2:0]         op);
      logic [C_WIDTH:0]   sum;
      logic [C_WIDTH-1:0] r;
      logic               c, v;
      sum = '0;
      r   = '0;
      c   = 1'b0;
      v   = 1'b0;
      case (op)
         OP_ADD: begin
            sum = {1'b0, a} + {1'b0, b};
            r   = sum[C_WIDTH-1:0];
            c   = sum[C_WIDTH];
            v   = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
         end
         OP_SUB: begin
            r = a - b;
            c = (a < b);
            v = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
         end
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_SHL:  r = a << b[SH_W-1:0];
         OP_SHR:  r = a >> b[SH_W-1:0];
         default: r = b;
      endcase
      return {r[MSB], (r == '0), c, v, r};
   endfunction

   // ---------------------------------------------------------------------------------
   // Control FSM and datapath registers
   state_t             state_q, state_n;
   logic [C_WIDTH-1:0] a_q, a_n, b_q, b_n, res_q, res_n, disp_q, disp_n;
   logic [2:0]         op_q, op_n;
   logic [3:0]         flags_q, flags_n;
`ifdef RPN_CHAIN_EN
   logic               hist_v_q, hist_v_n;
   logic [C_WIDTH-1:0] hist_res_q, hist_res_n;
   logic [3:0]         hist_flags_q, hist_flags_n;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_A;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         res_q        <= '0;
         flags_q      <= '0;
         disp_q       <= '0;
`ifdef RPN_CHAIN_EN
         hist_v_q     <= 1'b0;
         hist_res_q   <= '0;
         hist_flags_q <= '0;
`endif
      end else begin
         state_q      <= state_n;
         a_q          <= a_n;
         b_q          <= b_n;
         op_q         <= op_n;
         res_q        <= res_n;
         flags_q      <= flags_n;
         disp_q       <= disp_n;
`ifdef RPN_CHAIN_EN
         hist_v_q     <= hist_v_n;
         hist_res_q   <= hist_res_n;
         hist_flags_q <= hist_flags_n;
`endif
      end
   end

   always_comb begin
      state_n      = state_q;
      a_n          = a_q;
      b_n          = b_q;
      op_n         = op_q;
      res_n        = res_q;
      flags_n      = flags_q;
      disp_n       = '0;
`ifdef RPN_CHAIN_EN
      hist_v_n     = hist_v_q;
      hist_res_n   = hist_res_q;
      hist_flags_n = hist_flags_q;
`endif
      // Undo has priority over a coincident enter
      if (undo_p) begin
         case (state_q)
            S_B: begin
               state_n = S_A;
`ifdef RPN_CHAIN_EN
               if (hist_v_q) begin
                  state_n  = S_RES;
                  res_n    = hist_res_q;
                  flags_n  = hist_flags_q;
                  hist_v_n = 1'b0;
               end
`endif
            end
            S_OP: state_n = S_B;
            S_RES: begin
               state_n = S_OP;
               flags_n = '0;
            end
            default: ;
         endcase
      end else if (enter_p) begin
         case (state_q)
            S_A: begin
               a_n     = value;
               state_n = S_B;
            end
            S_B: begin
               b_n     = value;
               state_n = S_OP;
            end
            S_OP: begin
               op_n             = value[2:0];
               {flags_n, res_n} = alu_eval(a_q, b_q, value[2:0]);
               state_n          = S_RES;
`ifdef RPN_CHAIN_EN
               hist_v_n         = 1'b0;
`endif
            end
            default: begin
`ifdef RPN_CHAIN_EN
               a_n          = res_q;
               hist_v_n     = 1'b1;
               hist_res_n   = res_q;
               hist_flags_n = flags_q;
               state_n      = S_B;
`else
               state_n      = S_A;
`endif
            end
         endcase
      end

      case (state_n)
         S_A, S_B: disp_n = value;
         S_OP:     disp_n = C_WIDTH'(value[2:0]);
         default:  disp_n = res_n;
      endcase
   end

   assign display = disp_q;
   assign flags   = flags_q;
   assign state   = state_q;

endmodule

// File: tb/tb_rpn_calc_core.sv
// Bench for rpn_calc_core: directed scenarios plus random enter/undo sequences against a step model.
module tb_rpn_calc_core;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         enter, undo;
   logic [W-1:0] value;
   logic [W-1:0] display;
   logic [3:0]   flags;
   logic [1:0]   state;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   int           m_state;
   logic [W-1:0] m_a, m_b, m_res;
   logic [3:0]   m_flags;
   bit           m_hist;
   logic [W-1:0] m_hres;
   logic [3:0]   m_hflags;

   rpn_calc_core #(.C_WIDTH(W), .C_DEBOUNCER_DELAY(10), .C_BUTTON_EDGE(1'b0)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enter   (enter),
      .undo    (undo),
      .value   (value),
      .display (display),
      .flags   (flags),
      .state   (state)
   );

   always #5 clk = ~clk;

   // Plain-integer ALU: returns {N,Z,C,V,result}
   function automatic logic [W+3:0] ref_alu(input int unsigned a, input int unsigned b,
                                            input int unsigned op);
      int unsigned r;
      int          sa, sb, sr;
      bit          c, v;
      sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
      sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
      c  = 1'b0;
      v  = 1'b0;
      r  = 0;
      case (op)
         0: begin r = a + b; c = (r > 65535); sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
         1: begin r = a - b; c = (a < b);     sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = a << (b % 16);
         6: r = a >> (b % 16);
         default: r = b;
      endcase
      r = r % 65536;
      return {r >= 32768, r == 0, c, v, W'(r)};
   endfunction

   task automatic model_reset();
      m_state = 0; m_a = '0; m_b = '0; m_res = '0; m_flags = '0;
      m_hist = 1'b0; m_hres = '0; m_hflags = '0;
   endtask

   task automatic model_enter(input logic [W-1:0] v);
      case (m_state)
         0: begin m_a = v; m_state = 1; end
         1: begin m_b = v; m_state = 2; end
         2: begin {m_flags, m_res} = ref_alu(m_a, m_b, int'(v[2:0])); m_state = 3; m_hist = 1'b0; end
         default: begin
`ifdef RPN_CHAIN_EN
            m_hist = 1'b1; m_hres = m_res; m_hflags = m_flags; m_a = m_res; m_state = 1;
`else
            m_state = 0;
`endif
         end
      endcase
   endtask

   task automatic model_undo();
      case (m_state)
         1: if (m_hist) begin
               m_state = 3; m_res = m_hres; m_flags = m_hflags; m_hist = 1'b0;
            end else m_state = 0;
         2: m_state = 1;
         3: begin m_state = 2; m_flags = '0; end
         default: ;
      endcase
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Press with bounce on both edges; bounce runs are at most 3 cycles
   task automatic press(input bit do_enter, input bit do_undo, input int hold);
      bit lvl;
      int n;
      lvl = 1'b0;
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
         lvl = ~lvl; enter = do_enter & lvl; undo = do_undo & lvl;
         wait_cyc($urandom_range(1, 3));
      end
      enter = do_enter; undo = do_undo;
      wait_cyc(hold);
      lvl = 1'b1;
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
         lvl = ~lvl; enter = do_enter & lvl; undo = do_undo & lvl;
         wait_cyc($urandom_range(1, 3));
      end
      enter = 1'b0; undo = 1'b0;
      wait_cyc(20);
   endtask

   task automatic do_enter(input logic [W-1:0] v);
      value = v;
      press(1'b1, 1'b0, 20);
      model_enter(v);
   endtask

   task automatic do_undo();
      press(1'b0, 1'b1, 20);
      model_undo();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wait_cyc(3);
      rst_n = 1'b1;
      model_reset();
      wait_cyc(2);
   endtask

   task automatic check(input string tag);
      logic [W-1:0] ed;
      @(negedge clk);
      case (m_state)
         0, 1:    ed = value;
         2:       ed = W'(value[2:0]);
         default: ed = m_res;
      endcase
      n_cmp++;
      assert (state === 2'(m_state)) else begin
         n_fail++; $error("FAIL %s state: got %0d expected %0d", tag, state, m_state);
      end
      n_cmp++;
      assert (display === ed) else begin
         n_fail++; $error("FAIL %s display: got %h expected %h", tag, display, ed);
      end
      n_cmp++;
      assert (flags === m_flags) else begin
         n_fail++; $error("FAIL %s flags: got %b expected %b", tag, flags, m_flags);
      end
   endtask

   task automatic check_const(input string tag, input logic [W-1:0] ed, input logic [3:0] ef,
                              input logic [1:0] es);
      @(negedge clk);
      n_cmp++;
      assert (display === ed && flags === ef && state === es) else begin
         n_fail++;
         $error("FAIL %s: got disp=%h flags=%b state=%0d expected disp=%h flags=%b state=%0d",
                tag, display, flags, state, ed, ef, es);
      end
   endtask

   initial begin
      rst_n = 1'b0; enter = 1'b0; undo = 1'b0; value = '0;
      model_reset();
      wait_cyc(3);
      check_const("reset", 16'h0000, 4'b0000, 2'd0);
      rst_n = 1'b1;
      wait_cyc(2);
      check("after_reset");

      // signed overflow on ADD
      do_enter(16'h7FFF); check("t1_a");
      do_enter(16'h0001); check("t1_b");
      do_enter(16'h0000); check("t1_res");
      check_const("t1_const", 16'h8000, 4'b1001, 2'd3);

      // SUB with borrow, then undo clears flags
      do_reset();
      do_enter(16'h0003); do_enter(16'h0005); do_enter(16'h0001);
      check_const("t2_sub", 16'hFFFE, 4'b1010, 2'd3);
      do_undo(); check("t2_undo");
      check_const("t2_undo_const", 16'h0001, 4'b0000, 2'd2);

      // ADD wrapping to zero: Z and C
      do_reset();
      do_enter(16'hFFFF); do_enter(16'h0001); do_enter(16'h0008);
      check_const("zero_carry", 16'h0000, 4'b0110, 2'd3);

      // Bounce shorter than the delay never advances; a long hold advances once
      do_reset();
      value = 16'h1234;
      for (int i = 0; i < 40; i += 3) begin
         enter = ~enter;
         wait_cyc(3);
      end
      enter = 1'b0;
      wait_cyc(20);
      check("t3_bounce");
      enter = 1'b1;
      wait_cyc(200);
      enter = 1'b0;
      wait_cyc(20);
      model_enter(value);
      check("t3_hold");

      // Coincident enter and undo in S_OP: undo wins
      do_enter(16'h00F0); check("t4_op");
      value = 16'h0002;
      press(1'b1, 1'b1, 20);
      model_undo();
      check("t4_both");

      // Reset in the middle of a debounce from S_OP
      do_enter(16'h0055); check("t5_op");
      value = 16'h0ABC;
      enter = 1'b1;
      wait_cyc(6);
      rst_n = 1'b0;
      wait_cyc(2);
      check_const("t5_in_reset", 16'h0000, 4'b0000, 2'd0);
      rst_n = 1'b1;
      model_reset();
      wait_cyc(8);
      check("t5_early");
      wait_cyc(17);
      model_enter(value);
      check("t5_full_delay");
      enter = 1'b0;
      wait_cyc(20);

`ifdef RPN_CHAIN_EN
      do_reset();
      do_enter(16'h0002); do_enter(16'h0003); do_enter(16'h0000);
      check_const("t6_five", 16'h0005, 4'b0000, 2'd3);
      do_enter(16'h0777); check("t6_chain");
      do_undo();
      check_const("t6_restore", 16'h0005, 4'b0000, 2'd3);
      do_enter(16'h0004); do_enter(16'h0004); do_enter(16'h0000);
      check_const("t6_nine", 16'h0009, 4'b0000, 2'd3);
`endif

      // Random enter/undo walk
      do_reset();
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 3) == 0) do_undo();
         else do_enter(W'($urandom));
         check($sformatf("rand%0d", k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
